// File: rtl/arisc_pkg.sv
// Shared types for the A-RISC multi-cycle core.
// Opcodes, FSM states and the 16-bit instruction layout.
package arisc_pkg;

  typedef enum logic [3:0] {
    OP_END, OP_ADD, OP_SUB, OP_MUL,
    OP_LDI, OP_LOAD, OP_STORE, OP_MOV,
    OP_JMP, OP_BZ, OP_BNZ, OP_AND,
    OP_OR, OP_XOR, OP_RSV14, OP_RSV15
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEMRD
  } state_t;

  typedef struct packed {
    logic [3:0] rb;
    logic [3:0] ra;
    logic [3:0] rd;
    op_t        op;
  } instr_t;

  function automatic logic alu_wb(op_t op);
    return op inside {OP_ADD, OP_SUB, OP_MUL,
                      OP_LDI, OP_MOV, OP_AND,
                      OP_OR, OP_XOR};
  endfunction

endpackage

// File: rtl/arisc_alu.sv
// A-RISC ALU: register-writing arithmetic/logic ops.
// LDI passes the immediate in on b; MOV passes a.
module arisc_alu
  import arisc_pkg::*;
#(
  parameter int W = 8
) (
  input  op_t          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_MOV:  y = a;
      OP_LDI:  y = b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/arisc_cpu.sv
// A-RISC core: IDLE/FETCH/EXEC/MEMRD FSM, PC,
// register file and branch logic around arisc_alu.
module arisc_cpu
  import arisc_pkg::*;
#(
  parameter int NUM_GPR = 8,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  output logic         idle,
  output logic [W-1:0] iram_addr,
  input  logic [15:0]  iram_dout,
  output logic [W-1:0] dram_addr,
  output logic [W-1:0] dram_din,
  output logic         dram_write,
  input  logic [W-1:0] dram_dout
);

  localparam int RW = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;

  state_t        state, state_n;
  logic [W-1:0]  pc, pc_n, pc_inc, imm;
  logic [W-1:0]  gpr [NUM_GPR];
  logic [RW-1:0] ra_i, rb_i, rd_i, ld_rd;
  logic [W-1:0]  ra_v, rb_v, rd_v, alu_b, alu_y;
  logic          rf_we, take;
  logic [RW-1:0] rf_wa;
  logic [W-1:0]  rf_wd;
  instr_t        ins;
  logic          unused_ok;

  assign ins       = instr_t'(iram_dout);
  assign unused_ok = ^ins;
  assign ra_i      = ins.ra[RW-1:0];
  assign rb_i      = ins.rb[RW-1:0];
  assign rd_i      = ins.rd[RW-1:0];
  assign imm       = W'({ins.rb, ins.ra});
  assign ra_v      = gpr[ra_i];
  assign rb_v      = gpr[rb_i];
  assign rd_v      = gpr[rd_i];
  assign pc_inc    = pc + W'(1);
  assign alu_b     = (ins.op == OP_LDI) ? imm : rb_v;
  assign iram_addr = pc;

  always_comb begin
    take = 1'b0;
    unique case (1'b1)
      ins.op == OP_JMP: take = 1'b1;
      ins.op == OP_BZ:  take = (rd_v == '0);
      ins.op == OP_BNZ: take = (rd_v != '0);
      default:          take = 1'b0;
    endcase
  end

  arisc_alu #(.W(W)) u_alu (
    .op (ins.op),
    .a  (ra_v),
    .b  (alu_b),
    .y  (alu_y)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_FETCH;
      S_FETCH: state_n = S_EXEC;
      S_EXEC: begin
        if (ins.op == OP_END)       state_n = S_IDLE;
        else if (ins.op == OP_LOAD) state_n = S_MEMRD;
        else                        state_n = S_FETCH;
      end
      S_MEMRD: state_n = S_FETCH;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    idle       = (state == S_IDLE);
    dram_write = 1'b0;
    dram_addr  = '0;
    dram_din   = '0;
    if (state == S_EXEC) begin
      if (ins.op == OP_STORE) begin
        dram_write = 1'b1;
        dram_addr  = ra_v;
        dram_din   = rb_v;
      end else if (ins.op == OP_LOAD) begin
        dram_addr  = ra_v;
      end
    end
  end

  always_comb begin
    pc_n  = pc;
    rf_we = 1'b0;
    rf_wa = rd_i;
    rf_wd = alu_y;
    unique case (state)
      S_IDLE: if (start) pc_n = '0;
      S_EXEC: begin
        if (ins.op != OP_END && ins.op != OP_LOAD) begin
          pc_n  = take ? imm : pc_inc;
          rf_we = alu_wb(ins.op);
        end
      end
      S_MEMRD: begin
        pc_n  = pc_inc;
        rf_we = 1'b1;
        rf_wa = ld_rd;
        rf_wd = dram_dout;
      end
      default: pc_n = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc    <= '0;
      ld_rd <= '0;
      for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
    end else begin
      pc <= pc_n;
      if (state == S_EXEC) ld_rd <= rd_i;
      if (rf_we) gpr[rf_wa] <= rf_wd;
    end
  end

endmodule

// File: tb/tb_arisc_cpu.sv
// Bench for arisc_cpu: directed programs plus random
// forward-branching programs against an ISA-level model.
module tb_arisc_cpu;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        idle;
  logic [7:0]  iram_addr, dram_addr, dram_din, dram_dout;
  logic [15:0] iram_dout;
  logic        dram_write;

  logic [15:0] iram [256];
  logic [7:0]  dram [256];
  logic [7:0]  dram_init [256];
  logic [7:0]  md [256];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  arisc_cpu #(.NUM_GPR(8), .W(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .idle       (idle),
    .iram_addr  (iram_addr),
    .iram_dout  (iram_dout),
    .dram_addr  (dram_addr),
    .dram_din   (dram_din),
    .dram_write (dram_write),
    .dram_dout  (dram_dout)
  );

  always @(posedge clk) iram_dout <= iram[iram_addr];

  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 256; i++) dram[i] <= dram_init[i];
    end else if (dram_write) begin
      dram[dram_addr] <= dram_din;
    end
    dram_dout <= dram[dram_addr];
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic logic [15:0] ins3(int op, int d, int a, int b);
    logic [3:0] o4, d4, a4, b4;
    o4 = 4'(op); d4 = 4'(d); a4 = 4'(a); b4 = 4'(b);
    return {b4, a4, d4, o4};
  endfunction

  function automatic logic [15:0] insi(int op, int d, int imm);
    logic [3:0] o4, d4;
    logic [7:0] i8;
    o4 = 4'(op); d4 = 4'(d); i8 = 8'(imm);
    return {i8, d4, o4};
  endfunction

  task automatic clr_prog();
    for (int i = 0; i < 256; i++) begin
      iram[i] = 16'h0000;
      dram_init[i] = 8'h00;
    end
  endtask

  // ISA interpreter: registers indexed mod 8, all math mod 256
  task automatic model(output int cyc, output int nst);
    int r [8];
    int pc, op, d, a, b, imm, va, vb;
    bit done;
    for (int i = 0; i < 8; i++) r[i] = 0;
    for (int i = 0; i < 256; i++) md[i] = dram_init[i];
    pc = 0; cyc = 0; nst = 0; done = 0;
    for (int s = 0; s < 1000 && !done; s++) begin
      op  = int'(iram[pc][3:0]);
      d   = int'(iram[pc][7:4]) % 8;
      a   = int'(iram[pc][11:8]) % 8;
      b   = int'(iram[pc][15:12]) % 8;
      imm = int'(iram[pc][15:8]);
      va  = r[a];
      vb  = r[b];
      cyc += 2;
      case (op)
        0:  done = 1;
        1:  r[d] = (va + vb) % 256;
        2:  r[d] = (va - vb + 256) % 256;
        3:  r[d] = (va * vb) % 256;
        4:  r[d] = imm;
        5:  begin r[d] = int'(md[va]); cyc += 1; end
        6:  begin md[va] = 8'(vb); nst++; end
        7:  r[d] = va;
        11: r[d] = va & vb;
        12: r[d] = va | vb;
        13: r[d] = va ^ vb;
        default: ;
      endcase
      if (!done) begin
        if (op == 8 || (op == 9 && r[d] == 0) || (op == 10 && r[d] != 0))
          pc = imm;
        else
          pc = (pc + 1) % 256;
      end
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    rstn  = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic run(input string tag, input int xstart);
    int cyc, nst, e, st, viol, bad;
    model(cyc, nst);
    do_reset();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    e = 0; st = 0; viol = 0;
    forever begin
      if (dram_write) st++;
      else if (dram_din != 8'h00) viol++;
      if (idle && dram_write) viol++;
      if (idle || e >= 3000) break;
      @(negedge clk);
      e++;
      start = (e == xstart);
    end
    start = 1'b0;
    chk({tag, ".cycles"}, e, cyc);
    chk({tag, ".stores"}, st, nst);
    chk({tag, ".dram_quiet"}, viol, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (dram[i] !== md[i]) bad++;
    chk({tag, ".mem_diffs"}, bad, 0);
  endtask

  task automatic abort_run(input string tag, input bit on_store);
    int e;
    do_reset();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    e = 0;
    while (e < 200 && (on_store ? !dram_write : e < 20)) begin
      @(negedge clk);
      e++;
    end
    chk({tag, ".reached"}, int'(e < 200), 1);
    #2 rstn = 1'b0;
    #1;
    chk({tag, ".idle"}, int'(idle), 1);
    chk({tag, ".dwr"}, int'(dram_write), 0);
    chk({tag, ".pc"}, int'(iram_addr), 0);
    @(negedge clk) rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, ".stays_idle"}, int'(idle), 1);
  endtask

  task automatic prog_tri();
    clr_prog();
    iram[0] = insi(4, 1, 10);
    iram[1] = insi(4, 3, 1);
    iram[2] = ins3(1, 2, 2, 1);
    iram[3] = ins3(2, 1, 1, 3);
    iram[4] = insi(10, 1, 2);
    iram[5] = 16'h000E;
    iram[6] = insi(8, 0, 8);
    iram[7] = ins3(6, 0, 0, 0);
    iram[8] = ins3(6, 0, 0, 2);
    iram[9] = 16'h0000;
  endtask

  task automatic prog_arith();
    clr_prog();
    iram[0]  = insi(4, 1, 5);
    iram[1]  = insi(4, 2, 3);
    iram[2]  = ins3(1, 3, 1, 2);
    iram[3]  = ins3(6, 0, 0, 3);
    iram[4]  = ins3(2, 4, 1, 2);
    iram[5]  = insi(4, 5, 1);
    iram[6]  = ins3(6, 0, 5, 4);
    iram[7]  = insi(4, 1, 200);
    iram[8]  = insi(4, 2, 2);
    iram[9]  = ins3(3, 6, 1, 2);
    iram[10] = insi(4, 5, 2);
    iram[11] = ins3(6, 0, 5, 6);
    iram[12] = 16'h0000;
  endtask

  initial begin
    int op, tgt;

    clr_prog();
    do_reset();
    chk("reset.idle", int'(idle), 1);
    chk("reset.pc", int'(iram_addr), 0);
    chk("reset.dwr", int'(dram_write), 0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("end.idle_low1", int'(idle), 0);
    @(negedge clk);
    chk("end.idle_low2", int'(idle), 0);
    chk("end.dwr", int'(dram_write), 0);
    @(negedge clk);
    chk("end.idle_high", int'(idle), 1);
    run("end", -1);

    prog_arith();
    run("arith", -1);
    chk("arith.add", int'(dram[0]), 8);
    chk("arith.sub", int'(dram[1]), 2);
    chk("arith.mul", int'(dram[2]), 144);

    clr_prog();
    dram_init[0] = 8'd7;
    iram[0] = ins3(5, 1, 0, 0);
    iram[1] = ins3(6, 0, 1, 1);
    run("load", -1);
    chk("load.st", int'(dram[7]), 7);

    prog_tri();
    run("tri", -1);
    chk("tri.sum", int'(dram[0]), 55);

    abort_run("rst_loop", 1'b0);
    run("tri_rerun", -1);
    chk("tri_rerun.sum", int'(dram[0]), 55);

    prog_arith();
    abort_run("rst_store", 1'b1);

    prog_tri();
    run("tri_restart", 7);
    chk("tri_restart.sum", int'(dram[0]), 55);

    clr_prog();
    iram[0]   = insi(10, 7, 3);
    iram[1]   = insi(4, 7, 1);
    iram[2]   = insi(8, 0, 255);
    iram[255] = ins3(6, 0, 7, 7);
    run("wrap", -1);
    chk("wrap.st", int'(dram[1]), 1);

    for (int t = 0; t < 10; t++) begin
      clr_prog();
      for (int i = 0; i < 256; i++) dram_init[i] = 8'($urandom);
      for (int i = 0; i < 24; i++) begin
        op = $urandom_range(15, 1);
        if (op >= 8 && op <= 10) begin
          tgt = i + $urandom_range(4, 1);
          if (tgt > 24) tgt = 24;
          iram[i] = insi(op, $urandom_range(15), tgt);
        end else begin
          iram[i] = ins3(op, $urandom_range(15),
                         $urandom_range(15), $urandom_range(15));
        end
      end
      run($sformatf("rand%0d", t), (t % 3 == 0) ? 9 : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
